// File: rtl/fft_pkg.sv
// Shared radix-16 FFT datapath constants and lane helpers.
// The legacy R16 input alignment uses a fixed two-stage delay.
package fft_pkg;
    localparam int FFT_D_WIDTH   = 64;
    localparam int FFT_LANES     = 16;
    localparam int FFT_R16_DEPTH = 2;

    function automatic logic [FFT_D_WIDTH-1:0] lane_slice(
        input logic [FFT_LANES*FFT_D_WIDTH-1:0] bus,
        input int unsigned                      k
    );
        return bus[k*FFT_D_WIDTH +: FFT_D_WIDTH];
    endfunction
endpackage

// File: rtl/dly_stage.sv
// One delay-pipe stage: a lane-data-plus-valid register, one cycle when en_i is high.
// en_i low holds the contents; flush_i clears them and overrides en_i.
module dly_stage
    import fft_pkg::*;
#(
    parameter int W = FFT_LANES*FFT_D_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic [W-1:0] dat_i,
    output logic [W-1:0] dat_o
);

    logic [W-1:0] dat_q;
    logic [W-1:0] dat_d;

    always_comb begin
        dat_d = dat_q;
        if (flush_i) begin
            dat_d = '0;
        end else if (en_i) begin
            dat_d = dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= '0;
        end else begin
            dat_q <= dat_d;
        end
    end

    assign dat_o = dat_q;

endmodule

// File: rtl/r16_delay_pipe.sv
// Runtime-selectable 0..MAX_DEPTH cycle multi-lane delay with a valid tag per beat.
// Latency is eff_depth enabled cycles; en=0 freezes every stage, so no beat is lost.
module r16_delay_pipe
    import fft_pkg::*;
#(
    parameter int D_WIDTH   = FFT_D_WIDTH,
    parameter int LANES     = FFT_LANES,
    parameter int MAX_DEPTH = 8,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic [DEPTH_W-1:0]       depth_sel,
    input  logic                     in_valid,
    input  logic [LANES*D_WIDTH-1:0] data_in,
    output logic                     out_valid,
    output logic [LANES*D_WIDTH-1:0] data_out,
    output logic                     busy,
    output logic                     depth_err
);

    localparam int                 SW      = LANES*D_WIDTH + 1;
    localparam logic [DEPTH_W-1:0] MAX_SEL = DEPTH_W'(MAX_DEPTH);

    // Index 0 is the live input; the valid tag rides in the MSB of every stage.
    logic [SW-1:0]      stage [0:MAX_DEPTH];
    logic [DEPTH_W-1:0] eff_depth;
    logic [SW-1:0]      tap;
    logic               busy_c;
    logic               depth_err_q;
    logic               depth_err_d;

    assign stage[0] = {in_valid, data_in};

    for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
        dly_stage #(.W(SW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (en),
            .flush_i (flush),
            .dat_i   (stage[i]),
            .dat_o   (stage[i+1])
        );
    end

    assign eff_depth = (depth_sel > MAX_SEL) ? MAX_SEL : depth_sel;

    always_comb begin
        tap    = stage[0];
        busy_c = 1'b0;
        for (int i = 1; i <= MAX_DEPTH; i++) begin
            if (eff_depth == DEPTH_W'(i)) begin
                tap = stage[i];
            end
            if (DEPTH_W'(i) <= eff_depth) begin
                busy_c = busy_c | stage[i][SW-1];
            end
        end
    end

    assign depth_err_d = (depth_sel > MAX_SEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_err_q <= 1'b0;
        end else begin
            depth_err_q <= depth_err_d;
        end
    end

    assign out_valid = tap[SW-1];
    assign data_out  = tap[SW-2:0];
    assign busy      = busy_c;
    assign depth_err = depth_err_q;

endmodule
